// File: rtl/instruction_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues one word read at a time to instruction
// memory and buffers returned words in a small FIFO presented to decode.
// Branches flush the FIFO and discard any in-flight read; fetching the all-zero
// word parks the unit in HALT until the next branch.
module instruction_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk1,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        halted
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   pc_inc;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;

    // Head of the FIFO goes straight to decode from the storage registers.
    assign instr_valid = (count != '0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign pop         = instr_valid && instr_ready;
    // Only a live (non-dropped) request that completes without a redirect is kept.
    assign push        = (state == REQ) && mem_ack && !branch_valid;
    assign pc_inc      = pc + 32'd4;

    // Occupancy after this cycle's push/pop; decides whether a back-to-back request fits.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_ONE;
        else if (!push && pop)
            count_next = count - CNT_ONE;
    end

    // Capture fetched word and its address into the tail slot.
    always_ff @(posedge clk1) begin
        if (!rst && push) begin
            fifo_instr[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]    <= mem_addr;
        end
    end

    // Fetch FSM, PC, request handshake and FIFO pointer bookkeeping.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            halted   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (branch_valid) begin
            // Flush wins over any pop: the decoder already took the old head.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= branch_target & ~32'h3;
            halted <= 1'b0;
            if ((state == REQ || state == DROP) && !mem_ack) begin
                // Read still outstanding: keep the handshake alive, throw the data away.
                state <= DROP;
            end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        pc <= pc_inc;
                        if (mem_rdata == 32'h0) begin
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                            state   <= HALT;
                        end else if (count_next < FULL) begin
                            mem_addr <= pc_inc;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                HALT: begin
                    mem_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
